// File: rtl/mem_bridge48.sv
// Multi-cycle bridge from the CPU memory stage to a 16-bit synchronous RAM.
// Each 48/16/8-bit load or store is split into 16-bit beats; loads are reassembled and extended.
module mem_bridge48 #(
  parameter int ADDR_W = 16,
  parameter int LAT    = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              WE,
  input  logic [2:0]        CTRL,
  input  logic [47:0]       ADDRESS,
  input  logic [47:0]       WDATA,
  output logic [47:0]       READ,
  output logic              WAIT,
  output logic              DONE,
  output logic              ERR,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [1:0]        MEM_BE,
  output logic [15:0]       MEM_WD,
  input  logic [15:0]       MEM_RD
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LATWAIT, S_FINISH} state_t;
  localparam logic [1:0] LAT_LAST = 2'(LAT - 1);

  state_t              r_state, w_nxt_state;
  logic                r_we, r_a0, r_err;
  logic [2:0]          r_ctrl;
  logic [ADDR_W-1:0]   r_base;
  logic [47:0]         r_wdata;
  logic [1:0]          r_beat, r_lcnt;
  logic [15:0]         r_slot [3];
  logic [47:0]         r_read;
  logic                r_done, r_errp, r_men, r_mwe;
  logic [ADDR_W-1:0]   r_maddr;
  logic [1:0]          r_mbe;
  logic [15:0]         r_mwd;

  logic                w_idle, w_we, w_a0, w_bad, w_capture, w_nxt_err;
  logic [2:0]          w_ctrl;
  logic [ADDR_W-1:0]   w_base, w_d_addr;
  logic [47:0]         w_wdata, w_asm;
  logic [1:0]          w_nb, w_beat_p1, w_nxt_beat, w_nxt_lcnt, w_d_be;
  logic [15:0]         w_d_wd, w_s0, w_s1, w_s2;
  logic [7:0]          w_byte;
  logic                w_unused;

  assign w_unused = ^ADDRESS[47:ADDR_W+1];

  // In IDLE the request is being latched this edge, so beat-0 drive comes from the inputs.
  assign w_idle    = (r_state == S_IDLE);
  assign w_we      = w_idle ? WE                  : r_we;
  assign w_ctrl    = w_idle ? CTRL                : r_ctrl;
  assign w_a0      = w_idle ? ADDRESS[0]          : r_a0;
  assign w_base    = w_idle ? ADDRESS[ADDR_W:1]   : r_base;
  assign w_wdata   = w_idle ? WDATA               : r_wdata;
  assign w_bad     = (CTRL > 3'd4) || (ADDRESS[0] && (CTRL <= 3'd2));
  assign w_nb      = (r_ctrl == 3'd0) ? 2'd3 : 2'd1;
  assign w_beat_p1 = r_beat + 2'd1;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_beat  = r_beat;
    w_nxt_lcnt  = r_lcnt;
    w_nxt_err   = r_err;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ) begin
          w_nxt_err   = w_bad;
          w_nxt_beat  = 2'd0;
          w_nxt_state = w_bad ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_nxt_beat  = w_beat_p1;
          w_nxt_state = (w_beat_p1 < w_nb) ? S_ISSUE : S_FINISH;
        end else begin
          w_nxt_lcnt  = LAT_LAST;
          w_nxt_state = S_LATWAIT;
        end
      end
      S_LATWAIT: begin
        if (r_lcnt == 2'd0) begin
          w_capture   = 1'b1;
          w_nxt_beat  = w_beat_p1;
          w_nxt_state = (w_beat_p1 < w_nb) ? S_ISSUE : S_FINISH;
        end else begin
          w_nxt_lcnt  = r_lcnt - 2'd1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Drive for the beat about to be issued.
  always_comb begin
    w_d_wd = w_wdata[15:0];
    w_d_be = 2'b11;
    case (w_ctrl)
      3'd0: begin
        case (w_nxt_beat)
          2'd1:    w_d_wd = w_wdata[31:16];
          2'd2:    w_d_wd = w_wdata[47:32];
          default: w_d_wd = w_wdata[15:0];
        endcase
      end
      3'd1, 3'd2: w_d_wd = w_wdata[15:0];
      default: begin
        w_d_wd = {2{w_wdata[7:0]}};
        w_d_be = w_a0 ? 2'b10 : 2'b01;
      end
    endcase
  end
  assign w_d_addr = w_base + ADDR_W'(w_nxt_beat);

  // The final beat lands in its slot on the same edge READ is loaded, so bypass it.
  assign w_s0 = (w_capture && r_beat == 2'd0) ? MEM_RD : r_slot[0];
  assign w_s1 = (w_capture && r_beat == 2'd1) ? MEM_RD : r_slot[1];
  assign w_s2 = (w_capture && r_beat == 2'd2) ? MEM_RD : r_slot[2];

  always_comb begin
    w_byte = r_a0 ? w_s0[15:8] : w_s0[7:0];
    w_asm  = 48'h0;
    case (r_ctrl)
      3'd0:    w_asm = {w_s2, w_s1, w_s0};
      3'd1:    w_asm = {32'h0, w_s0};
      3'd2:    w_asm = {{32{w_s0[15]}}, w_s0};
      3'd3:    w_asm = {40'h0, w_byte};
      3'd4:    w_asm = {{40{w_byte[7]}}, w_byte};
      default: w_asm = 48'h0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_nxt_state;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_we    <= 1'b0;
      r_ctrl  <= 3'd0;
      r_a0    <= 1'b0;
      r_base  <= '0;
      r_wdata <= 48'h0;
      r_err   <= 1'b0;
      r_beat  <= 2'd0;
      r_lcnt  <= 2'd0;
      for (int i = 0; i < 3; i++) r_slot[i] <= 16'h0;
      r_read  <= 48'h0;
      r_done  <= 1'b0;
      r_errp  <= 1'b0;
      r_men   <= 1'b0;
      r_mwe   <= 1'b0;
      r_maddr <= '0;
      r_mbe   <= 2'b00;
      r_mwd   <= 16'h0;
    end else begin
      if (w_idle && REQ) begin
        r_we    <= WE;
        r_ctrl  <= CTRL;
        r_a0    <= ADDRESS[0];
        r_base  <= ADDRESS[ADDR_W:1];
        r_wdata <= WDATA;
      end
      r_err  <= w_nxt_err;
      r_beat <= w_nxt_beat;
      r_lcnt <= w_nxt_lcnt;
      for (int i = 0; i < 3; i++)
        if (w_capture && r_beat == 2'(i)) r_slot[i] <= MEM_RD;
      r_men   <= (w_nxt_state == S_ISSUE);
      r_mwe   <= (w_nxt_state == S_ISSUE) && w_we;
      r_maddr <= (w_nxt_state == S_ISSUE) ? w_d_addr : '0;
      r_mbe   <= (w_nxt_state == S_ISSUE) ? w_d_be   : 2'b00;
      r_mwd   <= (w_nxt_state == S_ISSUE) ? w_d_wd   : 16'h0;
      r_done  <= (w_nxt_state == S_FINISH);
      r_errp  <= (w_nxt_state == S_FINISH) && w_nxt_err;
      if (w_nxt_state == S_FINISH) begin
        if (w_nxt_err) r_read <= 48'h0;
        else if (!r_we) r_read <= w_asm;
      end
    end
  end

  assign WAIT     = (r_state != S_FINISH) && (REQ || (r_state != S_IDLE));
  assign READ     = r_read;
  assign DONE     = r_done;
  assign ERR      = r_errp;
  assign MEM_EN   = r_men;
  assign MEM_WE   = r_mwe;
  assign MEM_ADDR = r_maddr;
  assign MEM_BE   = r_mbe;
  assign MEM_WD   = r_mwd;

endmodule

// File: tb/tb_mem_bridge48.sv
// Bench for mem_bridge48: one bridge at LAT=1 and one at LAT=3, each on its own RAM,
// checked against a memory-array reference model derived from the access rules.
module tb_mem_bridge48;
  logic        clk = 1'b0;
  logic        rst;
  logic        req [2];
  logic        we  [2];
  logic [2:0]  ctrl [2];
  logic [47:0] addr [2];
  logic [47:0] wdat [2];
  logic [47:0] rdat [2];
  logic        wt [2], dn [2], er [2], men [2], mwe [2];
  logic [15:0] maddr [2];
  logic [1:0]  mbe [2];
  logic [15:0] mwd [2], mrd [2];

  logic [15:0] ram  [2][65536];
  logic [15:0] rp   [2][3];
  logic        ram_clr;
  logic [15:0] refm [2][65536];
  logic [47:0] exp_read [2];

  int n_cmp = 0, n_bad = 0;
  int gcyc = 0;
  int last_rel, last_abs, last_start;

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  mem_bridge48 #(.ADDR_W(16), .LAT(1)) u_lat1 (
    .CLK(clk), .RESET(rst), .REQ(req[0]), .WE(we[0]), .CTRL(ctrl[0]), .ADDRESS(addr[0]),
    .WDATA(wdat[0]), .READ(rdat[0]), .WAIT(wt[0]), .DONE(dn[0]), .ERR(er[0]),
    .MEM_EN(men[0]), .MEM_WE(mwe[0]), .MEM_ADDR(maddr[0]), .MEM_BE(mbe[0]),
    .MEM_WD(mwd[0]), .MEM_RD(mrd[0]));

  mem_bridge48 #(.ADDR_W(16), .LAT(3)) u_lat3 (
    .CLK(clk), .RESET(rst), .REQ(req[1]), .WE(we[1]), .CTRL(ctrl[1]), .ADDRESS(addr[1]),
    .WDATA(wdat[1]), .READ(rdat[1]), .WAIT(wt[1]), .DONE(dn[1]), .ERR(er[1]),
    .MEM_EN(men[1]), .MEM_WE(mwe[1]), .MEM_ADDR(maddr[1]), .MEM_BE(mbe[1]),
    .MEM_WD(mwd[1]), .MEM_RD(mrd[1]));

  // Synchronous RAMs: byte-lane writes, read data delayed through a 3-deep pipe.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int u = 0; u < 2; u++)
        for (int a = 0; a < 65536; a++) ram[u][a] <= 16'h0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (men[u] && mwe[u]) begin
          if (mbe[u][0]) ram[u][maddr[u]][7:0]  <= mwd[u][7:0];
          if (mbe[u][1]) ram[u][maddr[u]][15:8] <= mwd[u][15:8];
        end
        rp[u][0] <= ram[u][maddr[u]];
        rp[u][1] <= rp[u][0];
        rp[u][2] <= rp[u][1];
      end
    end
  end
  assign mrd[0] = rp[0][0];
  assign mrd[1] = rp[1][2];

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] model_read(input int u, input logic [2:0] c, input logic [47:0] a);
    logic [15:0] b  = a[16:1];
    logic [15:0] h0 = refm[u][b];
    logic [15:0] h1 = refm[u][16'(b + 16'd1)];
    logic [15:0] h2 = refm[u][16'(b + 16'd2)];
    logic [7:0]  by = a[0] ? h0[15:8] : h0[7:0];
    case (c)
      3'd0:    return {h2, h1, h0};
      3'd1:    return {32'h0, h0};
      3'd2:    return {{32{h0[15]}}, h0};
      3'd3:    return {40'h0, by};
      3'd4:    return {{40{by[7]}}, by};
      default: return 48'h0;
    endcase
  endfunction

  task automatic model_store(input int u, input logic [2:0] c, input logic [47:0] a, input logic [47:0] wd);
    logic [15:0] b = a[16:1];
    if (c == 3'd0) begin
      refm[u][b] = wd[15:0];
      refm[u][16'(b + 16'd1)] = wd[31:16];
      refm[u][16'(b + 16'd2)] = wd[47:32];
    end else if (c <= 3'd2) begin
      refm[u][b] = wd[15:0];
    end else if (a[0]) begin
      refm[u][b][15:8] = wd[7:0];
    end else begin
      refm[u][b][7:0] = wd[7:0];
    end
  endtask

  task automatic txn(input int u, input logic w, input logic [2:0] c, input logic [47:0] a, input logic [47:0] wd);
    logic        bad   = (c > 3'd4) || (a[0] && c <= 3'd2);
    int          nb    = (c == 3'd0) ? 3 : 1;
    int          L     = (u == 0) ? 1 : 3;
    int          exp_c = bad ? 1 : (w ? 1 + nb : 1 + nb * (1 + L));
    logic [15:0] base  = a[16:1];
    logic [1:0]  ebe   = (c <= 3'd2) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    logic [15:0] ewd;
    int          cyc, beats;
    logic        seen;
    if (bad) exp_read[u] = 48'h0;
    else if (!w) exp_read[u] = model_read(u, c, a);
    @(negedge clk);
    cyc = dn[u] ? -1 : 0;
    req[u] = 1'b1; we[u] = w; ctrl[u] = c; addr[u] = a; wdat[u] = wd;
    #1;
    if (cyc == 0) begin
      chk("wait_c0", wt[u], 1);
      last_start = gcyc;
    end
    beats = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 0) begin
        chk("wait_c0", wt[u], 1);
        last_start = gcyc;
      end
      if (dn[u]) seen = 1'b1;
      else if (cyc > 0) begin
        chk("wait_busy", wt[u], 1);
        if (men[u]) begin
          chk("mem_addr", maddr[u], 16'(base + beats));
          chk("mem_we", mwe[u], w);
          chk("mem_be", mbe[u], ebe);
          if (w) begin
            if (c == 3'd0) ewd = 16'(wd >> (16 * beats));
            else if (c <= 3'd2) ewd = wd[15:0];
            else ewd = {wd[7:0], wd[7:0]};
            chk("mem_wd", mwd[u], ewd);
          end
          beats++;
        end
      end
    end
    chk("done_seen", seen, 1);
    chk("done_cyc", 48'(cyc), 48'(exp_c));
    chk("err", er[u], bad);
    chk("wait_fin", wt[u], 0);
    chk("beats", 48'(beats), bad ? 48'd0 : 48'(nb));
    chk("read", rdat[u], exp_read[u]);
    if (!bad && w) model_store(u, c, a, wd);
    last_rel = cyc;
    last_abs = gcyc;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req[0] = 1'b0; req[1] = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse0", dn[0], 0);
    chk("done_pulse1", dn[1], 0);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_txn(input int u);
    logic [2:0]  c  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    logic [47:0] a;
    logic [47:0] wd = {16'($urandom), $urandom};
    a[47:17] = 31'($urandom);
    a[16:0]  = ($urandom_range(0, 3) == 0) ? 17'(17'h1FFF0 + $urandom_range(0, 15)) : 17'($urandom_range(0, 63));
    txn(u, 1'($urandom), c, a, wd);
    if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; we[u] = 1'b0; ctrl[u] = 3'd0; addr[u] = 48'h0; wdat[u] = 48'h0;
      exp_read[u] = 48'h0;
      for (int a = 0; a < 65536; a++) refm[u][a] = 16'h0;
    end
    rst = 1'b1;
    ram_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ram_clr = 1'b0;
    chk("rst_read", rdat[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_err", er[0], 0);
    chk("rst_men", men[0], 0);
    chk("rst_maddr", maddr[0], 0);
    chk("rst_wait_lo", wt[0], req[0]);
    req[0] = 1'b1;
    #1 chk("rst_wait_hi", wt[0], req[0]);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Directed: 48-bit store/load, byte path, errors, back-to-back, wrap.
    txn(0, 1'b1, 3'd0, 48'h10, 48'h123456789ABC);
    chk("st48_cyc", 48'(last_rel), 4);
    chk("ram8", ram[0][8], 16'h9ABC);
    chk("ram9", ram[0][9], 16'h5678);
    chk("ram10", ram[0][10], 16'h1234);
    idle(1);
    txn(0, 1'b0, 3'd0, 48'h10, 48'h0);
    chk("ld48_cyc", 48'(last_rel), 7);
    chk("ld48_read", rdat[0], 48'h123456789ABC);
    idle(1);
    txn(0, 1'b1, 3'd3, 48'h21, 48'h0000000000A5);
    idle(1);
    txn(0, 1'b0, 3'd4, 48'h21, 48'h0);
    chk("ld8s_read", rdat[0], 48'hFFFFFFFFFFA5);
    idle(1);
    txn(0, 1'b0, 3'd3, 48'h21, 48'h0);
    chk("ld8z_read", rdat[0], 48'h0000000000A5);
    idle(1);
    txn(0, 1'b0, 3'd1, 48'h3, 48'h0);
    chk("err16_cyc", 48'(last_rel), 1);
    chk("err16_read", rdat[0], 0);
    idle(1);
    txn(0, 1'b0, 3'd7, 48'h10, 48'h0);
    chk("err111_cyc", 48'(last_rel), 1);
    idle(1);
    txn(0, 1'b0, 3'd1, 48'h10, 48'h0);
    s = last_start;
    chk("b2b_first", 48'(last_rel), 3);
    txn(0, 1'b0, 3'd1, 48'h12, 48'h0);
    chk("b2b_second", 48'(last_abs - s), 7);
    idle(1);
    txn(0, 1'b1, 3'd0, 48'h1FFFE, 48'h0003_0002_0001);
    chk("wrap_ffff", ram[0][16'hFFFF], 16'h0001);
    chk("wrap_0000", ram[0][0], 16'h0002);
    chk("wrap_0001", ram[0][1], 16'h0003);
    idle(1);

    // LAT=3 unit.
    txn(1, 1'b1, 3'd0, 48'h40, 48'hDEADBEEFCAFE);
    idle(1);
    txn(1, 1'b0, 3'd0, 48'h40, 48'h0);
    chk("lat3_cyc", 48'(last_rel), 13);
    chk("lat3_read", rdat[1], 48'hDEADBEEFCAFE);
    idle(1);

    for (int i = 0; i < 200; i++) rand_txn(0);
    idle(1);
    for (int i = 0; i < 30; i++) rand_txn(1);
    idle(1);

    // Abort a 48-bit store during its third beat.
    txn(0, 1'b1, 3'd0, 48'h0, 48'h1111_2222_3333);
    idle(1);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; ctrl[0] = 3'd0; addr[0] = 48'h0; wdat[0] = 48'hAAAA_BBBB_CCCC;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_en", men[0], 1);
    chk("abort_addr", maddr[0], 16'h2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_men", men[0], 0);
    chk("abort_done", dn[0], 0);
    chk("abort_read", rdat[0], 0);
    chk("abort_wait", wt[0], req[0]);
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_nodone", dn[0], 0);
    end
    chk("abort_hw0", ram[0][0], 16'hCCCC);
    chk("abort_hw1", ram[0][1], 16'hBBBB);
    chk("abort_hw2", ram[0][2], 16'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_bridge48.md
# mem_bridge48

Multi-cycle data-memory bridge between the CPU memory stage and a 16-bit-wide synchronous data RAM or peripheral port. It accepts one 48-bit, 16-bit or 8-bit load/store request at a time and splits it into 16-bit RAM beats. It raises `WAIT` to stall the pipeline while the access is in flight, then assembles, extends and returns load data. It sits directly downstream of the CPU memory stage, fed by `ALUOutM`, `WriteDataM`, `MemWriteM` and the 3-bit memory-control field.

## Interface
- `ADDR_W`, default 16: RAM halfword-address width.
- `LAT`, default 1: RAM read latency in cycles, legal range 1..3.

- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `REQ`  in  1: request valid from the memory stage; held high while stalled.
- `WE`  in  1: 1 = store, 0 = load.
- `CTRL`  in  3: access type.
  - 000: 48-bit.
  - 001: 16-bit zero-extended.
  - 010: 16-bit sign-extended.
  - 011: 8-bit zero-extended.
  - 100: 8-bit sign-extended.
  - Other codes are illegal.
- `ADDRESS`  in  48: byte address.
- `WDATA`  in  48: store data.
- `READ`  out  48: load result, registered.
- `WAIT`  out  1: pipeline stall request.
- `DONE`  out  1: one-cycle completion pulse.
- `ERR`  out  1: one-cycle error pulse, coincident with `DONE`.
- `MEM_EN`  out  1: RAM beat strobe.
- `MEM_WE`  out  1: RAM write enable.
- `MEM_ADDR`  out  ADDR_W: RAM halfword address.
- `MEM_BE`  out  2: byte lanes; bit0 = [7:0], bit1 = [15:8].
- `MEM_WD`  out  16: RAM write data.
- `MEM_RD`  in  16: RAM read data, valid `LAT` cycles after its `MEM_EN` cycle.

## Operation
- **FSM states:** IDLE, ISSUE, LATWAIT, FINISH. Reset enters IDLE.
- **Reset values:**
  - `READ` = 0.
  - `DONE`, `ERR`, `MEM_*` outputs and the beat counter = 0.
- **IDLE, `REQ` = 1:** latch `WE`, `CTRL`, `ADDRESS`, `WDATA`.
  - Base halfword address = `ADDRESS[ADDR_W:1]`; upper address bits are ignored.
  - Beat count: 3 for 48-bit, 1 otherwise.
  - Error check: illegal `CTRL`, or `ADDRESS[0]` = 1 on a 48-bit or 16-bit access.
  - Error → go to FINISH with `ERR` flagged; no `MEM_EN` is issued.
  - No error → go to ISSUE with beat = 0.
- **ISSUE:**
  - Drive `MEM_EN` = 1, `MEM_WE` = latched `WE`, `MEM_ADDR` = base + beat (modulo 2^ADDR_W, wraps silently).
  - 48-bit access: beat k carries `WDATA[16k+15:16k]`, little-endian; `MEM_BE` = 11.
  - 16-bit access: `MEM_BE` = 11, `MEM_WD` = `WDATA[15:0]`.
  - 8-bit access: `MEM_BE` = 01 if `ADDRESS[0]` = 0, else 10; `MEM_WD` = `{WDATA[7:0], WDATA[7:0]}`.
  - Store: advance beat; go to ISSUE again if beats remain, else FINISH.
  - Load: go to LATWAIT.
- **LATWAIT:**
  - Stay `LAT` cycles with `MEM_EN` = 0.
  - On the last cycle, capture `MEM_RD` into slot [beat], then advance beat.
  - Go back to ISSUE if beats remain, else FINISH.
- **FINISH:**
  - `DONE` = 1; `ERR` = 1 if flagged.
  - Load: `READ` = assembled value.
    - 48-bit: the three 16-bit slots concatenated.
    - 16-bit: slot0, zero- or sign-extended from bit 15.
    - 8-bit: selected lane, zero- or sign-extended from bit 7.
  - Error: `READ` = 0.
  - Store: `READ` unchanged.
  - Return to IDLE. `REQ` is not sampled in FINISH.
- **WAIT** = (state ≠ FINISH) & (`REQ` | state ≠ IDLE).
  - Combinational, so the stall takes effect in the same cycle `REQ` rises.
  - Low in FINISH so the pipeline advances on that edge.
  - A back-to-back request is seen in IDLE on the following cycle.
- **`REQ` mid-access:** changes to `REQ`, `ADDRESS` or `WDATA` after acceptance are ignored.
- **RESET mid-access:** the FSM aborts immediately and `MEM_EN` drops asynchronously. RAM beats already written remain written; no completion pulse is produced.

## Timing
- Cycle 0 = the first IDLE cycle with `REQ` = 1.
- `DONE` cycle:
  - Error: cycle 1.
  - Store: cycle 1 + beats (16/8-bit: 2; 48-bit: 4).
  - Load: cycle 1 + beats × (1 + LAT) (LAT = 1: 16/8-bit → 3, 48-bit → 7).
- `READ` becomes valid in the `DONE` cycle and is stable until the next load or error completion.
- `MEM_*` outputs are registered from FSM state and are valid only while `MEM_EN` = 1.

## Test plan
- **Reset:** assert `RESET` asynchronously mid-cycle → all outputs 0 and FSM in IDLE before the next edge; `WAIT` = `REQ`.
- **48-bit store then load, LAT = 1:** store `ADDRESS` = 0x10, `WDATA` = 0x1234_5678_9ABC → RAM halfwords 8/9/10 = 9ABC/5678/1234, `DONE` at cycle 4. Then load the same address → `READ` = 0x123456789ABC, `DONE` at cycle 7, `WAIT` high on cycles 0–6.
- **Byte path:**
  - 8-bit store of 0xA5 at `ADDRESS` = 0x21 → `MEM_BE` = 10, `MEM_WD` = A5A5.
  - Sign-extended byte load → `READ` = 0xFFFF_FFFF_FFA5.
  - Zero-extended byte load → `READ` = 0x0000_0000_00A5.
- **Errors:**
  - 16-bit load at `ADDRESS` = 0x3 → `DONE` and `ERR` at cycle 1, no `MEM_EN`, `READ` = 0.
  - `CTRL` = 111 → same response.
- **Back-to-back and wrap:**
  - `REQ` held high for two consecutive 16-bit loads → second accepted the cycle after FINISH, `DONE` at cycles 3 and 7.
  - 48-bit store at halfword 0xFFFF (`ADDR_W` = 16) → `MEM_ADDR` sequence FFFF, 0000, 0001.
- **LAT = 3 and abort:**
  - With `LAT` = 3, a 48-bit load completes with `DONE` at cycle 13.
  - Assert `RESET` during beat 2 of a 48-bit store → only halfwords 0–1 written, no `DONE`.
